// File: rtl/rps_pkg.sv
// Shared codes and state encoding for the stone-paper-scissors match sequencer.
package rps_pkg;

  localparam logic [1:0] MOVE_STONE    = 2'b00;
  localparam logic [1:0] MOVE_PAPER    = 2'b01;
  localparam logic [1:0] MOVE_SCISSORS = 2'b10;
  localparam logic [1:0] MOVE_INVALID  = 2'b11;

  localparam logic [1:0] RES_TIE = 2'b00;
  localparam logic [1:0] RES_P1  = 2'b01;
  localparam logic [1:0] RES_P2  = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    JUDGE,
    UPDATE,
    DONE
  } state_t;

  // Winner by score comparison, used when the round limit ends the match.
  function automatic logic [1:0] score_winner(input int unsigned a, input int unsigned b);
    if (a > b) return WIN_P1;
    if (b > a) return WIN_P2;
    return WIN_DRAW;
  endfunction

endpackage

// File: rtl/rps_match_ctrl_slot.sv
// Per-player move capture register: valid/ready handshake, invalid-code filter
// and a got flag that closes the slot until the next round clears it.
module rps_move_slot
  import rps_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [1:0] move_in,
  input  logic       valid,
  output logic       ready,
  output logic       capture,
  output logic       got,
  output logic [1:0] move
);

  logic       got_q, got_d;
  logic [1:0] move_q, move_d;

  assign ready   = enable && !got_q;
  // Code 11 never closes the slot, so ready stays high while it is offered.
  assign capture = valid && ready && (move_in != MOVE_INVALID);

  always_comb begin
    got_d  = got_q;
    move_d = move_q;
    if (clear) begin
      got_d = 1'b0;
    end else if (capture) begin
      got_d  = 1'b1;
      move_d = move_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      got_q  <= 1'b0;
      move_q <= MOVE_STONE;
    end else begin
      got_q  <= got_d;
      move_q <= move_d;
    end
  end

  assign got  = got_q;
  assign move = move_q;

endmodule

// File: rtl/rps_match_ctrl.sv
// Match sequencer: collects move pairs, runs the judge handshake, keeps score.
// Optional per-round collection timeout enabled by defining ROUND_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// COLLECT | gathering one move from each player
// JUDGE   | judge_req held until judge_ack
// UPDATE  | apply round result, decide match end
// DONE    | match finished, result held until next start
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int SCORE_W        = 4,
  parameter int WIN_TARGET     = 3,
  parameter int MAX_ROUNDS     = 9,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [1:0]         p1_move,
  input  logic               p1_valid,
  output logic               p1_ready,
  input  logic [1:0]         p2_move,
  input  logic               p2_valid,
  output logic               p2_ready,
  output logic               judge_req,
  output logic [1:0]         judge_a,
  output logic [1:0]         judge_b,
  input  logic               judge_ack,
  input  logic [1:0]         judge_res,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [7:0]         round_cnt,
  output logic               busy,
  output logic               match_done,
  output logic [1:0]         winner
);

  if (WIN_TARGET < 1 || WIN_TARGET > (2**SCORE_W) - 1 || MAX_ROUNDS < 1 ||
      MAX_ROUNDS > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("rps_match_ctrl: parameter out of range");
  end

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d;
  logic [SCORE_W-1:0] p2_score_q, p2_score_d;
  logic [7:0]         round_q, round_d;
  logic [1:0]         winner_q, winner_d;
  logic [1:0]         res_q, res_d;
  logic               judge_req_q, judge_req_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               slot_clear, slot_en;
  logic               p1_cap, p2_cap, p1_got, p2_got;
  logic               both_in;
  logic [SCORE_W-1:0] p1_new, p2_new;
  logic [7:0]         round_new;

  assign slot_en = (state_q == COLLECT) && ena;

  rps_move_slot u_slot_p1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (slot_clear),
    .enable  (slot_en),
    .move_in (p1_move),
    .valid   (p1_valid),
    .ready   (p1_ready),
    .capture (p1_cap),
    .got     (p1_got),
    .move    (judge_a)
  );

  rps_move_slot u_slot_p2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (slot_clear),
    .enable  (slot_en),
    .move_in (p2_move),
    .valid   (p2_valid),
    .ready   (p2_ready),
    .capture (p2_cap),
    .got     (p2_got),
    .move    (judge_b)
  );

  // Completing capture counts this cycle so JUDGE is entered on the capture edge.
  assign both_in   = (p1_got || p1_cap) && (p2_got || p2_cap);
  assign p1_new    = p1_score_q + SCORE_W'(res_q == RES_P1);
  assign p2_new    = p2_score_q + SCORE_W'(res_q == RES_P2);
  assign round_new = round_q + 8'd1;

`ifdef ROUND_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d     = state_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    round_d     = round_q;
    winner_d    = winner_q;
    res_d       = res_q;
    judge_req_d = judge_req_q;
    slot_clear  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start && ena) begin
          state_d    = COLLECT;
          p1_score_d = '0;
          p2_score_d = '0;
          round_d    = '0;
          winner_d   = WIN_NONE;
          slot_clear = 1'b1;
        end
      end
      COLLECT: begin
        if (both_in) begin
          state_d     = JUDGE;
          judge_req_d = 1'b1;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (tmo_q == '0) begin
          state_d = UPDATE;
          if (p1_got || p1_cap)      res_d = RES_P1;
          else if (p2_got || p2_cap) res_d = RES_P2;
          else                       res_d = RES_TIE;
        end
`endif
      end
      JUDGE: begin
        if (judge_ack) begin
          state_d     = UPDATE;
          res_d       = judge_res;
          judge_req_d = 1'b0;
        end
      end
      UPDATE: begin
        p1_score_d = p1_new;
        p2_score_d = p2_new;
        round_d    = round_new;
        if (p1_new == SCORE_W'(WIN_TARGET)) begin
          state_d  = DONE;
          winner_d = WIN_P1;
        end else if (p2_new == SCORE_W'(WIN_TARGET)) begin
          state_d  = DONE;
          winner_d = WIN_P2;
        end else if (round_new == 8'(MAX_ROUNDS)) begin
          state_d  = DONE;
          winner_d = score_winner(32'(p1_new), 32'(p2_new));
        end else begin
          state_d    = COLLECT;
          slot_clear = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == COLLECT) || (state_d == JUDGE) || (state_d == UPDATE);
    done_d = (state_d == DONE);

`ifdef ROUND_TIMEOUT_EN
    // Down-counter reloads on every entry to COLLECT; terminal count is zero.
    if (slot_clear)                             tmo_d = TMO_W'(TIMEOUT_CYCLES - 1);
    else if (state_q == COLLECT && tmo_q != '0) tmo_d = tmo_q - 1'b1;
    else                                        tmo_d = tmo_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      round_q     <= '0;
      winner_q    <= WIN_NONE;
      res_q       <= RES_TIE;
      judge_req_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      round_q     <= round_d;
      winner_q    <= winner_d;
      res_q       <= res_d;
      judge_req_q <= judge_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ROUND_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign judge_req  = judge_req_q;
  assign p1_score   = p1_score_q;
  assign p2_score   = p2_score_q;
  assign round_cnt  = round_q;
  assign busy       = busy_q;
  assign match_done = done_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Self-checking bench for rps_match_ctrl: directed steps plus randomized matches
// checked against a score-keeping model that plays the game rules directly.
module tb_rps_match_ctrl;

  localparam int SW = 4;
  localparam int WT = 2;
  localparam int MR = 3;
  localparam int TC = 20;

  logic          clk = 1'b0;
  logic          rst_n, ena, start;
  logic [1:0]    p1_move, p2_move;
  logic          p1_valid, p2_valid, p1_ready, p2_ready;
  logic          judge_req, judge_ack;
  logic [1:0]    judge_a, judge_b, judge_res;
  logic [SW-1:0] p1_score, p2_score;
  logic [7:0]    round_cnt;
  logic          busy, match_done;
  logic [1:0]    winner;

  int n_assert = 0;
  int n_fail   = 0;
  int ms1, ms2, mrounds;

  always #5 clk = ~clk;

  rps_match_ctrl #(
    .SCORE_W(SW), .WIN_TARGET(WT), .MAX_ROUNDS(MR), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .p1_move(p1_move), .p1_valid(p1_valid), .p1_ready(p1_ready),
    .p2_move(p2_move), .p2_valid(p2_valid), .p2_ready(p2_ready),
    .judge_req(judge_req), .judge_a(judge_a), .judge_b(judge_b),
    .judge_ack(judge_ack), .judge_res(judge_res),
    .p1_score(p1_score), .p2_score(p2_score), .round_cnt(round_cnt),
    .busy(busy), .match_done(match_done), .winner(winner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // stone 0, paper 1, scissors 2: the move one step ahead (mod 3) wins.
  function automatic logic [1:0] rps_outcome(input logic [1:0] a, input logic [1:0] b);
    int ia = int'(a);
    int ib = int'(b);
    if (ia == ib) return 2'b00;
    if ((ia + 1) % 3 == ib) return 2'b10;
    return 2'b01;
  endfunction

  function automatic bit model_done();
    return (ms1 == WT) || (ms2 == WT) || (mrounds == MR);
  endfunction

  function automatic int model_winner();
    if (ms1 == WT) return 1;
    if (ms2 == WT) return 2;
    if (ms1 > ms2) return 1;
    if (ms2 > ms1) return 2;
    return 3;
  endfunction

  task automatic start_match();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ms1 = 0; ms2 = 0; mrounds = 0;
    check("start_busy",   32'(busy), 1);
    check("start_p1s",    32'(p1_score), 0);
    check("start_p2s",    32'(p2_score), 0);
    check("start_round",  32'(round_cnt), 0);
    check("start_done",   32'(match_done), 0);
    check("start_winner", 32'(winner), 0);
    check("start_ready",  32'({p2_ready, p1_ready}), 3);
  endtask

  task automatic play_round(input logic [1:0] m1, input logic [1:0] m2, input bit same,
                            input int ack_dly, input bit bad_first, input bit ena_glitch,
                            input bit poke_start);
    logic [1:0] res;
    if (ena_glitch) begin
      ena = 1'b0; p1_move = m1; p1_valid = 1'b1;
      #1;
      check("ready_ena_low", 32'({p2_ready, p1_ready}), 0);
      @(negedge clk);
      ena = 1'b1;
      #1;
      check("no_cap_ena_low", 32'(p1_ready), 1);
    end
    if (bad_first) begin
      p1_move = 2'b11; p1_valid = 1'b1;
      @(negedge clk);
      check("invalid_not_captured", 32'(p1_ready), 1);
      check("invalid_no_req", 32'(judge_req), 0);
    end
    p1_move = m1; p1_valid = 1'b1;
    if (same) begin
      p2_move = m2; p2_valid = 1'b1;
    end
    @(negedge clk);
    p1_valid = 1'b0;
    if (!same) begin
      check("p1_ready_drop", 32'(p1_ready), 0);
      check("p2_still_ready", 32'(p2_ready), 1);
      check("req_wait_p2", 32'(judge_req), 0);
      p2_move = m2; p2_valid = 1'b1;
      @(negedge clk);
    end
    p2_valid = 1'b0;
    check("req_rise", 32'(judge_req), 1);
    check("judge_a", 32'(judge_a), 32'(m1));
    check("judge_b", 32'(judge_b), 32'(m2));
    res = rps_outcome(m1, m2);
    if (res == 2'b00 && $urandom_range(0, 1) == 1) res = 2'b11;
    for (int i = 0; i < ack_dly; i++) begin
      start = poke_start && (i == 0);
      ena = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0;
      check("req_hold", 32'(judge_req), 1);
      check("a_hold", 32'(judge_a), 32'(m1));
      check("b_hold", 32'(judge_b), 32'(m2));
      check("round_hold", 32'(round_cnt), mrounds);
    end
    ena = 1'b1;
    judge_ack = 1'b1; judge_res = res;
    @(negedge clk);
    judge_ack = 1'b0; judge_res = 2'b00;
    check("req_drop", 32'(judge_req), 0);
    check("score_latency", 32'(p1_score), ms1);
    if (res == 2'b01) ms1++;
    else if (res == 2'b10) ms2++;
    mrounds++;
    @(negedge clk);
    check("p1_score", 32'(p1_score), ms1);
    check("p2_score", 32'(p2_score), ms2);
    check("round_cnt", 32'(round_cnt), mrounds);
    if (model_done()) begin
      check("done", 32'(match_done), 1);
      check("winner", 32'(winner), model_winner());
      check("done_busy", 32'(busy), 0);
      check("done_ready", 32'({p2_ready, p1_ready}), 0);
    end else begin
      check("cont_busy", 32'(busy), 1);
      check("cont_done", 32'(match_done), 0);
      check("cont_ready", 32'({p2_ready, p1_ready}), 3);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit req_seen;
    rst_n = 1'b0; ena = 1'b0; start = 1'b0;
    p1_move = 2'b00; p2_move = 2'b00; p1_valid = 1'b0; p2_valid = 1'b0;
    judge_ack = 1'b0; judge_res = 2'b00;
    ms1 = 0; ms2 = 0; mrounds = 0;
    repeat (2) @(negedge clk);
    check("rst_outs", 32'({busy, match_done, winner, judge_req, p1_ready, p2_ready}), 0);
    check("rst_scores", 32'({p1_score, p2_score, round_cnt}), 0);
    check("rst_judge_ab", 32'({judge_a, judge_b}), 0);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_needs_ena", 32'(busy), 0);
    ena = 1'b1;
    @(negedge clk);
    check("idle_no_start", 32'(busy), 0);

    start_match();
    play_round(2'b00, 2'b10, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    play_round(2'b01, 2'b00, 1'b0, 5, 1'b0, 1'b0, 1'b1);

    ena = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ena = 1'b1;
    check("done_start_no_ena", 32'(match_done), 1);
    check("done_hold_score", 32'(p1_score), 2);

    start_match();
    play_round(2'b01, 2'b01, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    play_round(2'b10, 2'b10, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    play_round(2'b00, 2'b00, 1'b0, 2, 1'b0, 1'b0, 1'b1);

    for (int m = 0; m < 25; m++) begin
      start_match();
      while (!model_done()) begin
        play_round(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 3) == 0));
      end
    end

    start_match();
    play_round(2'b00, 2'b10, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    p1_move = 2'b01; p2_move = 2'b10; p1_valid = 1'b1; p2_valid = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0; p2_valid = 1'b0;
    check("pre_rst_req", 32'(judge_req), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outs", 32'({busy, match_done, winner, judge_req, p1_ready, p2_ready}), 0);
    check("midrst_scores", 32'({p1_score, p2_score, round_cnt}), 0);
    check("midrst_judge_ab", 32'({judge_a, judge_b}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", 32'({busy, judge_req}), 0);

`ifdef ROUND_TIMEOUT_EN
    start_match();
    p1_move = 2'b01; p1_valid = 1'b1;
    @(negedge clk);
    p1_valid = 1'b0;
    req_seen = 1'b0;
    for (int i = 0; i < TC + 10 && round_cnt == 8'd0; i++) begin
      @(negedge clk);
      if (judge_req) req_seen = 1'b1;
    end
    check("tmo_no_req", 32'(req_seen), 0);
    check("tmo_p1_score", 32'(p1_score), 1);
    check("tmo_p2_score", 32'(p2_score), 0);
    check("tmo_round", 32'(round_cnt), 1);
    for (int i = 0; i < TC + 10 && round_cnt == 8'd1; i++) begin
      @(negedge clk);
      if (judge_req) req_seen = 1'b1;
    end
    check("tmo_tie_no_req", 32'(req_seen), 0);
    check("tmo_tie_scores", 32'({p1_score, p2_score}), 32'({4'd1, 4'd0}));
    check("tmo_tie_round", 32'(round_cnt), 2);
`else
    req_seen = 1'b0;
    check("no_tmo_req", 32'(req_seen | judge_req), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rps_match_ctrl.md
Name: rps_match_ctrl

Overview:
- Match sequencer for the stone-paper-scissors game.
- Collects one move per player over per-player valid/ready handshakes and passes each move pair to the round judge datapath over a req/ack handshake.
- Accumulates per-player scores and declares the match winner at WIN_TARGET points or after MAX_ROUNDS rounds.
- Sits between the pin-level input decode and the judge logic inside the top-level project.

Parameters:
- SCORE_W, 4: width of each score counter.
- WIN_TARGET, 3: points that end the match immediately. Must be <= 2^SCORE_W-1.
- MAX_ROUNDS, 9: round limit. Range 1..255.
- TIMEOUT_CYCLES, 1000: move-collection timeout. Used only with ROUND_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ena  in  1  design enable; low blocks start and move capture.
- start  in  1  single-cycle pulse that begins a match.
- p1_move  in  2  player 1 move.
- p1_valid  in  1  player 1 move valid.
- p1_ready  out  1  controller ready for a player 1 move.
- p2_move  in  2  player 2 move.
- p2_valid  in  1  player 2 move valid.
- p2_ready  out  1  controller ready for a player 2 move.
- judge_req  out  1  judge request.
- judge_a  out  2  player 1 move presented to the judge.
- judge_b  out  2  player 2 move presented to the judge.
- judge_ack  in  1  judge acknowledge.
- judge_res  in  2  judge result: 00 tie, 01 p1 wins, 10 p2 wins, 11 treated as tie.
- p1_score  out  SCORE_W  player 1 score.
- p2_score  out  SCORE_W  player 2 score.
- round_cnt  out  8  rounds completed.
- busy  out  1  match in progress.
- match_done  out  1  match finished.
- winner  out  2  match winner: 01 p1, 10 p2, 11 draw.

Behaviour:
- Move encoding: 00 stone, 01 paper, 10 scissors. Code 11 is invalid and is never captured; ready stays high.
- Reset: state IDLE; all outputs and internal flags 0. A reset mid-match (any state) clears everything at that edge.
- IDLE: start && ena -> COLLECT. Scores, round_cnt, winner and capture flags cleared.
- COLLECT:
  - pN_ready = ena && !gotN.
  - A capture occurs on valid && ready && move != 11; the move is latched and gotN set.
  - Both players may be captured in the same cycle.
  - When both got flags are set -> JUDGE.
  - judge_req rises in the first cycle after the completing capture edge.
- JUDGE:
  - judge_req = 1 and judge_a/judge_b stable until judge_ack is sampled high.
  - On that edge judge_res is latched -> UPDATE; judge_req is low the next cycle.
  - ena is ignored here, so the handshake always completes.
- UPDATE (one cycle):
  - The winning player's score increments; a tie changes neither score. round_cnt increments.
  - If a score equals WIN_TARGET -> DONE, winner = that player.
  - Else if round_cnt == MAX_ROUNDS -> DONE, winner by higher score (equal scores = 11).
  - Else -> COLLECT with got flags cleared.
- DONE:
  - match_done = 1; scores and winner held.
  - start && ena -> COLLECT as a fresh match; scores, round_cnt and winner cleared.
- busy = 1 in COLLECT, JUDGE and UPDATE.
- start is ignored while busy.
- Score update latency: ack edge M -> new score visible after edge M+1.

Optional Feature:
- Macro: ROUND_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in COLLECT and clears on entry.
  - At TIMEOUT_CYCLES with exactly one player captured, that player wins the round. JUDGE is skipped and the controller goes straight to UPDATE; judge_req is never asserted.
  - At TIMEOUT_CYCLES with no player captured, the round is a tie and goes to UPDATE.
  - A completing capture on the expiry cycle takes priority over the timeout.
- Without the macro: COLLECT waits indefinitely; TIMEOUT_CYCLES is unused and no counter is synthesised.

Decomposition:
- Package rps_pkg holds:
  - move codes: MOVE_STONE, MOVE_PAPER, MOVE_SCISSORS, MOVE_INVALID;
  - result codes: RES_TIE, RES_P1, RES_P2;
  - winner codes;
  - the state enum: IDLE, COLLECT, JUDGE, UPDATE, DONE.
- One sub-module, rps_move_slot: per-player capture register with valid/ready, invalid-code filter and got flag. Instantiated twice.

Test Plan:
- Reset then start; p1=00, p2=10; judge model acks after 1 cycle with 01 -> p1_score=1, p2_score=0, round_cnt=1, state back to COLLECT.
- WIN_TARGET=2; p1 wins two consecutive rounds -> match_done=1, winner=01, busy=0, both ready low; second start clears scores to 0.
- MAX_ROUNDS=3; judge returns 00 three times -> DONE after round 3 with winner=11 and scores 0/0.
- p1 drives move 11 with valid high -> not captured, p1_ready stays high; then p1 drives 01 -> captured and p1_ready drops.
- judge_ack delayed 5 cycles -> judge_req high for exactly those cycles, judge_a/judge_b constant; start pulsed during JUDGE is ignored.
- rst_n low during JUDGE -> next edge: all outputs 0, state IDLE.
- With ROUND_TIMEOUT_EN, TIMEOUT_CYCLES=20: p1 moves, p2 silent -> p1_score=1 after timeout, judge_req never asserted.
